conv_stream_driver: RTL and testbench

Synthesizable frame source/sink for the 128x32 convolution core. It is the transmitting end of the core's x and f valid/ready input streams and the receiving end of its y output stream. The host preloads one frame (128 x samples, 32 f samples) through a write port and pulses `start`. The block then streams both inputs under backpressure, accepts the 97 results, and reports a count and a running checksum. It sits between the host/test harness and the convolution core, in place of behavioural stimulus.

---
 rtl/conv_stream_pkg.sv | 18 +
 rtl/stream_tx_channel.sv | 75 +++++++
 rtl/conv_stream_driver.sv | 105 ++++++++++
 tb/tb_conv_stream_driver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_pkg.sv
// Shared constants and FSM state type for the convolution frame driver.
package conv_stream_pkg;
    localparam int N    = 128;
    localparam int M    = 32;
    localparam int DW   = 8;
    localparam int YW   = 21;
    localparam int CW   = YW + 7;
    localparam int XAW  = $clog2(N);
    localparam int FAW  = $clog2(M);
    localparam int YCW  = 7;
    localparam int NRES = N - M + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drv_state_t;
endpackage

// File: rtl/stream_tx_channel.sv
// One buffered valid/ready source: preloaded sample array streamed out in index order.
module stream_tx_channel #(
    parameter int DEPTH = 128,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          start_i,
    input  logic          flush_i,
    input  logic          ready_i,
    output logic [W-1:0]  data_o,
    output logic          valid_o,
    output logic          last_sent_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] idx_q, idx_d, idx_nxt;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          fire, at_end;

    // Buffer is deliberately unreset so a preloaded frame survives reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign fire    = valid_q && ready_i;
    assign at_end  = (idx_q == AW'(DEPTH - 1));
    assign idx_nxt = idx_q + AW'(1);

    always_comb begin
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (start_i) begin
            idx_d   = '0;
            data_d  = mem_q[0];
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if (flush_i) begin
            valid_d = 1'b0;
        end else if (fire) begin
            if (at_end) begin
                valid_d = 1'b0;
                last_d  = 1'b1;
            end else begin
                idx_d  = idx_nxt;
                data_d = mem_q[idx_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign last_sent_o = last_q;
endmodule

// File: rtl/conv_stream_driver.sv
// Frame source/sink for the convolution core: streams x and f, collects y count and checksum.
module conv_stream_driver
    import conv_stream_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [6:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic [DW-1:0] m_data_x,
    output logic          m_valid_x,
    input  logic          m_ready_x,
    output logic [DW-1:0] m_data_f,
    output logic          m_valid_f,
    input  logic          m_ready_f,
    input  logic [YW-1:0] s_data_y,
    input  logic          s_valid_y,
    output logic          s_ready_y,
    input  logic          y_stall,
    output logic          busy,
    output logic          done,
    output logic [6:0]    y_count,
    output logic [CW-1:0] checksum
);
    drv_state_t      state_q, state_d;
    logic [YCW-1:0]  y_count_q, y_count_d;
    logic [CW-1:0]   csum_q, csum_d;
    logic            idle, go, wr_ok, y_fire, y_last;
    logic            x_last_sent, f_last_sent;

    assign idle   = (state_q == IDLE);
    assign go     = idle && start;
    assign wr_ok  = idle && wr_en;
    assign y_fire = s_valid_y && s_ready_y;
    assign y_last = y_fire && (y_count_q == YCW'(NRES - 1));

    always_comb begin
        state_d   = state_q;
        y_count_d = y_count_q;
        csum_d    = csum_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d   = RUN;
                y_count_d = '0;
                csum_d    = '0;
            end
            RUN: if (y_fire) begin
                y_count_d = y_count_q + YCW'(1);
                csum_d    = csum_q + {{(CW-YW){s_data_y[YW-1]}}, s_data_y};
                if (y_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            y_count_q <= '0;
            csum_q    <= '0;
        end else begin
            state_q   <= state_d;
            y_count_q <= y_count_d;
            csum_q    <= csum_d;
        end
    end

    // The final y transfer flushes any input samples the core never took.
    stream_tx_channel #(.DEPTH(N), .W(DW), .AW(XAW)) u_x (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en_i    (wr_ok && !wr_sel),
        .wr_addr_i  (wr_addr[XAW-1:0]),
        .wr_data_i  (wr_data),
        .start_i    (go),
        .flush_i    (y_last),
        .ready_i    (m_ready_x),
        .data_o     (m_data_x),
        .valid_o    (m_valid_x),
        .last_sent_o(x_last_sent)
    );

    stream_tx_channel #(.DEPTH(M), .W(DW), .AW(FAW)) u_f (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en_i    (wr_ok && wr_sel),
        .wr_addr_i  (wr_addr[FAW-1:0]),
        .wr_data_i  (wr_data),
        .start_i    (go),
        .flush_i    (y_last),
        .ready_i    (m_ready_f),
        .data_o     (m_data_f),
        .valid_o    (m_valid_f),
        .last_sent_o(f_last_sent)
    );

    assign s_ready_y = (state_q == RUN) && !y_stall;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign y_count   = y_count_q;
    assign checksum  = csum_q;
endmodule

// File: tb/tb_conv_stream_driver.sv
// Randomized bench for conv_stream_driver against a frame-level reference model.
module tb_conv_stream_driver;
    import conv_stream_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [6:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] m_data_x, m_data_f;
    logic          m_valid_x, m_valid_f;
    logic          m_ready_x = 1'b0, m_ready_f = 1'b0;
    logic [YW-1:0] s_data_y = '0;
    logic          s_valid_y = 1'b0, y_stall = 1'b0;
    logic          s_ready_y, busy, done;
    logic [6:0]    y_count;
    logic [CW-1:0] checksum;

    always #5 clk = ~clk;

    conv_stream_driver dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .m_data_x(m_data_x), .m_valid_x(m_valid_x),
        .m_ready_x(m_ready_x), .m_data_f(m_data_f), .m_valid_f(m_valid_f), .m_ready_f(m_ready_f),
        .s_data_y(s_data_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y), .y_stall(y_stall),
        .busy(busy), .done(done), .y_count(y_count), .checksum(checksum)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame in progress flag, per-channel element index, result tallies.
    logic [DW-1:0] xb [N];
    logic [DW-1:0] fb [M];
    bit            md_run = 0, md_dn = 0, pdn;
    int            xi = 0, fi = 0, cnt = 0;
    logic [CW-1:0] sum = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_run = 0; md_dn = 0; xi = 0; fi = 0; cnt = 0; sum = '0;
        end else begin
            pdn   = md_dn;
            md_dn = 0;
            if (md_run) begin
                if (xi < N && m_ready_x) xi++;
                if (fi < M && m_ready_f) fi++;
                if (s_valid_y && !y_stall) begin
                    cnt++;
                    sum = sum + CW'($signed(s_data_y));
                    if (cnt == N - M + 1) begin
                        md_run = 0;
                        md_dn  = 1;
                    end
                end
            end else if (!pdn) begin
                if (wr_en) begin
                    if (wr_sel) fb[wr_addr[4:0]] = wr_data;
                    else        xb[wr_addr]      = wr_data;
                end
                if (start) begin
                    md_run = 1; xi = 0; fi = 0; cnt = 0; sum = '0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            chk("busy", busy, md_run);
            chk("done", done, md_dn);
            chk("s_ready_y", s_ready_y, md_run && !y_stall);
            chk("y_count", y_count, cnt);
            chk("checksum", checksum, sum);
            chk("valid_x", m_valid_x, md_run && xi < N);
            chk("valid_f", m_valid_f, md_run && fi < M);
            if (md_run && xi < N) chk("data_x", m_data_x, xb[xi]);
            if (md_run && fi < M) chk("data_f", m_data_f, fb[fi]);
        end
    end

    task automatic wr(input bit sel, input int addr, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 7'(addr); wr_data = d;
        @(posedge clk); #3;
        wr_en = 1'b0;
    endtask

    // Runs one frame from start to DONE; called at 3 time units after an edge.
    task automatic run_frame(input int rmode, input bit yhold, input bit junk,
                             input bit pin5, output int nx);
        int  n;
        bit  p5;
        n = 0; nx = 0; p5 = 0;
        start = 1'b1; wr_en = 1'b0; s_valid_y = 1'b0;
        m_ready_x = (rmode != 1) ? 1'b1 : 1'b1;
        @(posedge clk); #1;
        while (n < 3000 && !md_dn) begin
            if (m_valid_x && m_ready_x) nx++;
            if (pin5 && !p5 && md_run && xi == 5 && m_valid_x) begin
                chk("x5_kept", m_data_x, 8'd5);
                p5 = 1;
            end
            #2;
            start   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_en   = junk ? ($urandom_range(0, 2) == 0) : 1'b0;
            wr_sel  = 1'($urandom_range(0, 1));
            wr_addr = 7'($urandom);
            wr_data = DW'($urandom);
            if (junk && n == 0) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd5; wr_data = 8'h7F;
            end
            case (rmode)
                0:       begin m_ready_x = 1'b1; m_ready_f = 1'b1; end
                1:       begin m_ready_x = ((n + 1) % 3 == 0); m_ready_f = 1'($urandom_range(0, 1)); end
                default: begin m_ready_x = 1'($urandom_range(0, 1)); m_ready_f = 1'($urandom_range(0, 1)); end
            endcase
            s_valid_y = (yhold && xi < N) ? 1'b0 : 1'($urandom_range(0, 1));
            s_data_y  = YW'($urandom);
            y_stall   = ($urandom_range(0, 3) == 0);
            n++;
            @(posedge clk); #1;
        end
        if (!md_dn) chk("frame_timeout", 32'd0, 32'd1);
        if (pin5 && !p5) chk("x5_seen", 32'd0, 32'd1);
        #2;
        start = 1'b0; wr_en = 1'b0; s_valid_y = 1'b0; y_stall = 1'b0;
    endtask

    initial begin
        int nx, n;

        // Reset held: outputs idle regardless of start.
        start = 1'b1;
        #23;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid_x", m_valid_x, 1'b0);
        chk("rst_valid_f", m_valid_f, 1'b0);
        chk("rst_data_x", m_data_x, 8'd0);
        chk("rst_s_ready", s_ready_y, 1'b0);
        chk("rst_count", y_count, 7'd0);
        chk("rst_checksum", checksum, 28'd0);
        @(posedge clk); #1;
        chk("rst_start_ignored", busy, 1'b0);
        start = 1'b0;
        #3 reset_n = 1'b1;
        @(posedge clk); #3;

        // Ramp frame with readies tied high.
        for (int i = 0; i < N; i++) wr(1'b0, i, DW'(i));
        for (int j = 0; j < M; j++) wr(1'b1, j, DW'(j + 1));
        m_ready_x = 1'b1; m_ready_f = 1'b1;
        start = 1'b1;
        for (int k = 0; k <= N; k++) begin
            @(posedge clk); #1;
            if (k < N) chk("ramp_x", {m_valid_x, m_data_x}, {1'b1, 8'(k)});
            else       chk("ramp_x_end", m_valid_x, 1'b0);
            if (k < M)       chk("ramp_f", {m_valid_f, m_data_f}, {1'b1, 8'(k + 1)});
            else if (k == M) chk("ramp_f_end", m_valid_f, 1'b0);
            #2 start = 1'b0;
        end

        // 97 results of -1 with alternating stall.
        s_valid_y = 1'b1; s_data_y = '1; y_stall = 1'b0;
        n = 0;
        while (md_run && n < 500) begin
            @(posedge clk); #3;
            y_stall = ~y_stall;
            n++;
        end
        if (md_run) chk("y_timeout", 32'd0, 32'd1);
        chk("done_pulse", done, 1'b1);
        chk("final_count", y_count, 7'd97);
        chk("final_checksum", checksum, 28'hFFFFF9F);
        chk("extra_y_refused", s_ready_y, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("count_held", y_count, 7'd97);
        chk("extra_y_refused2", s_ready_y, 1'b0);
        #2 s_valid_y = 1'b0; y_stall = 1'b0;

        // Writes and start during RUN are ignored; next frame still carries x[5]=5.
        run_frame(0, 1'b0, 1'b1, 1'b0, nx);
        @(posedge clk); #3;
        run_frame(1, 1'b1, 1'b0, 1'b1, nx);
        chk("x_xfer_count", nx, N);
        @(posedge clk); #3;

        // Reset after 50 x transfers, then restart from x[0] with buffers intact.
        m_ready_x = 1'b1; m_ready_f = 1'b1; start = 1'b1;
        n = 0;
        while (xi < 50 && n < 200) begin
            @(posedge clk); #3;
            start = 1'b0;
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid_x", m_valid_x, 1'b0);
        chk("mid_rst_valid_f", m_valid_f, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_count", y_count, 7'd0);
        chk("mid_rst_data_x", m_data_x, 8'd0);
        start = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_start_ignored", busy, 1'b0);
        start = 1'b0;
        #1 reset_n = 1'b1;
        @(posedge clk); #3;
        run_frame(0, 1'b0, 1'b0, 1'b1, nx);
        @(posedge clk); #3;

        // Random frames.
        for (int fr = 0; fr < 3; fr++) begin
            for (int i = 0; i < N; i++) wr(1'b0, i, DW'($urandom));
            for (int j = 0; j < M; j++) wr(1'b1, j, DW'($urandom));
            run_frame(2, fr[0], 1'b1, 1'b0, nx);
            @(posedge clk); #3;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
